// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that gives one of four byte sources the UART TX path per message,
// with a per-grant byte cap (MAX_HOLD) and a 16-cycle idle timeout on the owner.
module uart_tx_arbiter #(
  parameter int MAX_HOLD = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  reqValid,
  input  logic [31:0] reqData,
  input  logic [3:0]  reqLast,
  output logic [3:0]  reqAck,
  input  logic        bufFull,
  output logic [7:0]  data,
  output logic        dataReady,
  output logic [3:0]  grant,
  output logic        busy
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [4:0] IDLE_LIMIT = 5'd15;

  typedef enum logic [1:0] {IDLE, LOCKED, ACKWAIT} state_t;

  state_t     state;
  logic [1:0] owner;
  logic [1:0] last_grant;
  logic [7:0] byte_cnt;
  logic [4:0] idle_cnt;
  logic       last_flag;
  logic [1:0] pick;

  // Lowest offset from last_grant+1 wins; offset 4 wraps to last_grant itself.
  function automatic logic [1:0] next_owner(input logic [3:0] valid, input logic [1:0] last);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (valid[idx]) sel = idx;
    end
    return sel;
  endfunction

  always_comb pick = next_owner(reqValid, last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 4'b0000;
      reqAck     <= 4'b0000;
      dataReady  <= 1'b0;
      data       <= 8'h00;
      busy       <= 1'b0;
      byte_cnt   <= 8'd0;
      idle_cnt   <= 5'd0;
      last_grant <= 2'd3;
      owner      <= 2'd0;
      last_flag  <= 1'b0;
    end else begin
      reqAck    <= 4'b0000;
      dataReady <= 1'b0;
      case (state)
        IDLE: begin
          if (|reqValid) begin
            owner    <= pick;
            grant    <= 4'b0001 << pick;
            busy     <= 1'b1;
            byte_cnt <= 8'd0;
            idle_cnt <= 5'd0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (reqValid[owner]) begin
            idle_cnt <= 5'd0;
            if (!bufFull) begin
              data      <= reqData[{owner, 3'b000} +: 8];
              dataReady <= 1'b1;
              reqAck    <= 4'b0001 << owner;
              last_flag <= reqLast[owner];
              if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
              state     <= ACKWAIT;
            end
          end else if (idle_cnt == IDLE_LIMIT) begin
            // 16th consecutive cycle without a byte from the owner
            grant      <= 4'b0000;
            busy       <= 1'b0;
            last_grant <= owner;
            idle_cnt   <= 5'd0;
            state      <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 5'd1;
          end
        end
        ACKWAIT: begin
          if (last_flag || byte_cnt == HOLD_LIMIT) begin
            grant      <= 4'b0000;
            busy       <= 1'b0;
            last_grant <= owner;
            idle_cnt   <= 5'd0;
            state      <= IDLE;
          end else begin
            state <= LOCKED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte sources feed the DUT,
// expected (requester, byte) pairs are queued and checked by a monitor on every strobe.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqValid, reqLast, reqAck, grant;
  logic [31:0] reqData;
  logic        bufFull, dataReady, busy;
  logic [7:0]  data;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [8:0] src_mem [4][64];
  int head     [4] = '{0, 0, 0, 0};
  int tail     [4] = '{0, 0, 0, 0};
  int flush_to [4] = '{0, 0, 0, 0};
  logic [9:0] exp_q [$];
  int strobe_cyc [$];

  uart_tx_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(rst), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
    .reqAck(reqAck), .bufFull(bufFull), .data(data), .dataReady(dataReady),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    src_mem[r][tail[r]] = {l, b};
    tail[r]++;
  endtask

  task automatic expect_byte(input int r, input logic [7:0] b);
    exp_q.push_back({2'(r), b});
  endtask

  task automatic flush_src();
    for (int r = 0; r < 4; r++) flush_to[r] = tail[r];
  endtask

  task automatic mid();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_strobe(input int max);
    int n = 0;
    while (!dataReady && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", dataReady, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bufFull = 1'b0;
    flush_src();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requester sources: present the head byte, advance on reqAck.
  initial begin
    reqValid = '0;
    reqData  = '0;
    reqLast  = '0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < 4; r++) begin
        if (reqAck[r] && head[r] < tail[r]) head[r]++;
        if (head[r] < flush_to[r]) head[r] = flush_to[r];
        if (head[r] < tail[r]) begin
          reqValid[r]      = 1'b1;
          reqData[8*r +: 8] = src_mem[r][head[r]][7:0];
          reqLast[r]       = src_mem[r][head[r]][8];
        end else begin
          reqValid[r]      = 1'b0;
          reqData[8*r +: 8] = 8'h00;
          reqLast[r]       = 1'b0;
        end
      end
    end
  end

  // Monitor: every strobe must match the head of the expected queue.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (dataReady) begin
        strobe_cyc.push_back(cyc);
        chk("strobe_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data", data, e[7:0]);
          chk("reqAck", reqAck, 32'(4'b0001 << e[9:8]));
          chk("grant_at_strobe", grant, 32'(4'b0001 << e[9:8]));
        end
      end else if (reqAck != 4'b0000) begin
        chk("ack_without_strobe", reqAck, 0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mark;
    rst = 1'b1;
    bufFull = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dataReady", dataReady, 0);
    chk("rst_data", data, 0);
    chk("rst_reqAck", reqAck, 0);
    rst = 1'b0;

    // Single message from requester 2
    mid();
    mark = strobe_cyc.size();
    expect_byte(2, 8'h41); expect_byte(2, 8'h42);
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_grant", grant, 4'b0100);
    chk("t1_busy", busy, 1);
    chk("t1_not_early", dataReady, 0);
    @(negedge clk);
    chk("t1_latency", dataReady, 1);
    wait_drain(20);
    chk("t1_gap", (strobe_cyc.size() == mark + 2) ? strobe_cyc[mark+1] - strobe_cyc[mark] : -1, 2);
    repeat (2) @(negedge clk);
    chk("t1_release_grant", grant, 0);
    chk("t1_release_busy", busy, 0);

    // Round-robin with all four requesting
    do_reset();
    mid();
    expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(2, 8'h12);
    expect_byte(3, 8'h13); expect_byte(0, 8'h14);
    push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    wait_drain(100);
    repeat (3) @(negedge clk);
    chk("t2_idle", grant, 0);

    // Backpressure while locked to requester 1
    mid();
    bufFull = 1'b1;
    expect_byte(1, 8'h43);
    push(1, 8'h43, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t3_grant", grant, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_dataReady", dataReady, 0);
      chk("t3_hold_reqAck", reqAck, 0);
    end
    bufFull = 1'b0;
    @(negedge clk);
    chk("t3_issue", dataReady, 1);
    wait_drain(10);
    repeat (3) @(negedge clk);

    // Forced release after MAX_HOLD=4 bytes; requester 3 is next
    do_reset();
    mid();
    for (int k = 0; k < 4; k++) expect_byte(1, 8'h51 + 8'(k));
    expect_byte(3, 8'h60);
    expect_byte(1, 8'h55); expect_byte(1, 8'h56);
    for (int k = 0; k < 6; k++) push(1, 8'h51 + 8'(k), 1'b0);
    push(3, 8'h60, 1'b1);
    wait_drain(100);
    chk("t4_still_owner", grant, 4'b0010);
    repeat (25) @(negedge clk);
    chk("t4_timeout_grant", grant, 0);

    // Idle timeout on requester 0
    mid();
    expect_byte(0, 8'h70);
    push(0, 8'h70, 1'b0);
    wait_strobe(10);
    repeat (14) @(negedge clk);
    chk("t5_held_grant", grant, 4'b0001);
    chk("t5_held_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("t5_timeout_grant", grant, 0);
    chk("t5_timeout_busy", busy, 0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a message
    mid();
    expect_byte(2, 8'h81);
    push(2, 8'h81, 1'b0); push(2, 8'h82, 1'b0); push(2, 8'h83, 1'b1);
    wait_strobe(10);
    #1;
    rst = 1'b1;
    flush_src();
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_dataReady", dataReady, 0);
    chk("t6_data", data, 0);
    chk("t6_reqAck", reqAck, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mid();
    expect_byte(0, 8'h90); expect_byte(2, 8'h91);
    push(0, 8'h90, 1'b1); push(2, 8'h91, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_first_grant", grant, 4'b0001);
    wait_drain(50);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 64, meaning the maximum bytes one requester sends per grant before forced release (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port reqValid, input, 4, requester i has a byte pending on bit i.
REQ-005 SHALL have port reqData, input, 32, byte of requester i on bits [8i+7:8i].
REQ-006 SHALL have port reqLast, input, 4, marks requester i's current byte as the end of its message.
REQ-007 SHALL have port reqAck, output, 4, one-cycle pulse on bit i when requester i's byte is taken.
REQ-008 SHALL have port bufFull, input, 1, backpressure from the downstream TX buffer; no byte is issued while high.
REQ-009 SHALL have port data, output, 8, byte to the TX buffer.
REQ-010 SHALL have port dataReady, output, 1, one-cycle strobe qualifying data.
REQ-011 SHALL have port grant, output, 4, one-hot owner of the TX path; all zero when idle.
REQ-012 SHALL have port busy, output, 1, high whenever grant is non-zero.

Function
REQ-013 SHALL implement FSM states IDLE, LOCKED and ACKWAIT; all outputs SHALL be registered.
REQ-014 In IDLE with any reqValid bit set, SHALL select the first set bit searching from lastGrant+1 modulo 4, register grant one-hot, clear the byte and idle counters, and enter LOCKED.
REQ-015 In LOCKED with reqValid[g] high and bufFull low, SHALL at the next edge load data from reqData byte g, pulse dataReady and reqAck[g] for one cycle, increment the byte counter, and enter ACKWAIT.
REQ-016 In LOCKED with bufFull high, SHALL issue no byte and hold all state except the idle counter.
REQ-017 reqLast[g] SHALL be sampled on the same edge as the transferred byte.
REQ-018 In ACKWAIT, a one-cycle state, SHALL go to IDLE if the sampled reqLast was 1 or the byte counter equals MAX_HOLD; otherwise it SHALL return to LOCKED.
REQ-019 On entry to IDLE, SHALL clear grant, set lastGrant to g, and keep busy low.
REQ-020 Back-to-back bytes SHALL have dataReady pulses at least 2 cycles apart; the first dataReady SHALL occur 2 cycles after reqValid is sampled in IDLE with bufFull low.
REQ-021 In LOCKED, reqValid[g] low for 16 consecutive cycles SHALL release the grant to IDLE; the idle counter SHALL reset on any cycle with reqValid[g] high.
REQ-022 reqValid of non-granted requesters SHALL be ignored; their reqAck SHALL stay 0.
REQ-023 The byte counter SHALL be 8 bits and SHALL not wrap within one grant.
REQ-024 A release and a new request on the same edge SHALL spend at least one cycle in IDLE before the next grant.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE, grant=0, reqAck=0, dataReady=0, data=0x00, busy=0, counters=0, and lastGrant=3, so requester 0 wins first.
REQ-026 Reset mid-message SHALL abandon the message with no further strobes; the first post-reset grant SHALL follow REQ-014.

Verification
REQ-027 Single message: requester 2 sends 0x41, 0x42 (reqLast on 0x42) -> dataReady pulses 2 cycles apart with data 0x41 then 0x42, reqAck[2] twice, grant back to 0 after ACKWAIT.
REQ-028 Round-robin: all four requesters request continuously, one byte each with reqLast=1 -> grant order 0,1,2,3,0.
REQ-029 Backpressure: bufFull high for 5 cycles during LOCKED -> no dataReady or reqAck during those cycles; byte 0x43 is issued on the edge after bufFull falls.
REQ-030 Forced release: MAX_HOLD=4, requester 1 streams 6 bytes with no reqLast and requester 3 waiting -> 4 bytes sent, then grant=0b1000.
REQ-031 Idle timeout: grant to requester 0, reqValid[0] dropped for 16 cycles -> grant=0, busy=0, no strobe.
REQ-032 Async reset asserted mid-message between clock edges -> all outputs 0 before the next edge; after release requester 0 is granted first.
